// File: rtl/lvds_panel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lvds_panel_sequencer
// Purpose  : Power/enable sequencer for an LVDS panel. Brings up panel VDD,
//            the LVDS transmitter and the backlight in datasheet order with
//            parameterised dwell times, and powers them down in reverse
//            order. Blanking is released only on a frame boundary.
// Ports    : clk_in        pixel-slot clock (serializer domain)
//            rst_n         asynchronous active-low reset
//            power_req     level, 1 = panel requested on
//            frame_start   one-cycle pulse at vertical counter wrap
//            panel_vdd_en  panel VDD switch
//            lvds_en       serializer clock/data lane enable
//            backlight_en  backlight enable
//            blank         1 = serializer forces RGB to zero
//            ready         panel on and displaying
//            state         current state code (debug/LEDs)
//            fault         sticky frame watchdog fault
// Options  : LVDS_SEQ_WATCHDOG_EN - compiles in the frame watchdog that forces
//            a power-down when frame_start stops arriving in RUN.
// Revision : 1.0 - initial release
// ============================================================================
module lvds_panel_sequencer #(
    parameter int               CNT_W         = 24,
    parameter logic [CNT_W-1:0] T_VDD_LVDS    = CNT_W'(1800000),
    parameter logic [CNT_W-1:0] T_LVDS_BL     = CNT_W'(3600000),
    parameter logic [CNT_W-1:0] T_BL_LVDS     = CNT_W'(3600000),
    parameter logic [CNT_W-1:0] T_LVDS_VDD    = CNT_W'(1800000),
    parameter logic [CNT_W-1:0] T_OFF_MIN     = CNT_W'(9000000),
    parameter logic [CNT_W-1:0] FRAME_TIMEOUT = CNT_W'(4000000)
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       power_req,
    input  logic       frame_start,
    output logic       panel_vdd_en,
    output logic       lvds_en,
    output logic       backlight_en,
    output logic       blank,
    output logic       ready,
    output logic [2:0] state,
    output logic       fault
);

    localparam logic [2:0] c_st_off      = 3'd0;
    localparam logic [2:0] c_st_vdd_on   = 3'd1;
    localparam logic [2:0] c_st_lvds_on  = 3'd2;
    localparam logic [2:0] c_st_run      = 3'd3;
    localparam logic [2:0] c_st_bl_off   = 3'd4;
    localparam logic [2:0] c_st_lvds_off = 3'd5;
    localparam logic [2:0] c_st_cool     = 3'd6;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    // Counter load values are T-1 so that leaving on count==0 gives exactly
    // T cycles of dwell; a zero dwell is stretched to one cycle.
    localparam logic [CNT_W-1:0] c_ld_vdd_lvds = (T_VDD_LVDS == '0) ? '0 : T_VDD_LVDS - c_one;
    localparam logic [CNT_W-1:0] c_ld_lvds_bl  = (T_LVDS_BL  == '0) ? '0 : T_LVDS_BL  - c_one;
    localparam logic [CNT_W-1:0] c_ld_bl_lvds  = (T_BL_LVDS  == '0) ? '0 : T_BL_LVDS  - c_one;
    localparam logic [CNT_W-1:0] c_ld_lvds_vdd = (T_LVDS_VDD == '0) ? '0 : T_LVDS_VDD - c_one;
    localparam logic [CNT_W-1:0] c_ld_off_min  = (T_OFF_MIN  == '0) ? '0 : T_OFF_MIN  - c_one;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_framed;     // a frame_start has been seen in this RUN visit
    logic             r_fault;
    logic             r_vdd;
    logic             r_lvds;
    logic             r_bl;
    logic             r_blank;
    logic             r_ready;

    logic [2:0]       w_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_framed_next;
    logic             w_fault_next;
    logic             w_timeout;
    logic             w_dwell_done;

    assign w_dwell_done = (r_cnt == '0);

    // Next-state logic. A dropped power_req always wins over dwell expiry.
    always_comb begin
        w_next        = r_state;
        w_load        = 1'b0;
        w_load_val    = '0;
        w_framed_next = 1'b0;
        w_fault_next  = r_fault;
        case (r_state)
            c_st_off: begin
                if (!power_req) begin
                    w_fault_next = 1'b0;
                end else if (!r_fault) begin
                    w_next     = c_st_vdd_on;
                    w_load     = 1'b1;
                    w_load_val = c_ld_vdd_lvds;
                end
            end
            c_st_vdd_on: begin
                if (!power_req) begin
                    w_next     = c_st_cool;
                    w_load     = 1'b1;
                    w_load_val = c_ld_off_min;
                end else if (w_dwell_done) begin
                    w_next     = c_st_lvds_on;
                    w_load     = 1'b1;
                    w_load_val = c_ld_lvds_bl;
                end
            end
            c_st_lvds_on: begin
                if (!power_req) begin
                    w_next     = c_st_lvds_off;
                    w_load     = 1'b1;
                    w_load_val = c_ld_lvds_vdd;
                end else if (w_dwell_done) begin
                    w_next = c_st_run;
                end
            end
            c_st_run: begin
                if (!power_req) begin
                    w_next     = c_st_bl_off;
                    w_load     = 1'b1;
                    w_load_val = c_ld_bl_lvds;
                end else if (w_timeout) begin
                    w_next       = c_st_bl_off;
                    w_load       = 1'b1;
                    w_load_val   = c_ld_bl_lvds;
                    w_fault_next = 1'b1;
                end else begin
                    w_framed_next = r_framed | frame_start;
                end
            end
            c_st_bl_off: begin
                if (w_dwell_done) begin
                    w_next     = c_st_lvds_off;
                    w_load     = 1'b1;
                    w_load_val = c_ld_lvds_vdd;
                end
            end
            c_st_lvds_off: begin
                if (w_dwell_done) begin
                    w_next     = c_st_cool;
                    w_load     = 1'b1;
                    w_load_val = c_ld_off_min;
                end
            end
            c_st_cool: begin
                if (w_dwell_done) begin
                    w_next = c_st_off;
                end
            end
            default: begin
                w_next = c_st_off;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state register.
    logic w_vdd_next;
    logic w_lvds_next;
    logic w_bl_next;
    logic w_ready_next;

    assign w_vdd_next   = (w_next == c_st_vdd_on) || (w_next == c_st_lvds_on) ||
                          (w_next == c_st_run)    || (w_next == c_st_bl_off)  ||
                          (w_next == c_st_lvds_off);
    assign w_lvds_next  = (w_next == c_st_lvds_on) || (w_next == c_st_run) ||
                          (w_next == c_st_bl_off);
    assign w_bl_next    = (w_next == c_st_run);
    assign w_ready_next = (w_next == c_st_run) && w_framed_next;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_off;
            r_cnt    <= '0;
            r_framed <= 1'b0;
            r_fault  <= 1'b0;
            r_vdd    <= 1'b0;
            r_lvds   <= 1'b0;
            r_bl     <= 1'b0;
            r_blank  <= 1'b1;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_framed <= w_framed_next;
            r_fault  <= w_fault_next;
            if (w_load) begin
                r_cnt <= w_load_val;
            end else if (!w_dwell_done) begin
                r_cnt <= r_cnt - c_one;
            end
            r_vdd   <= w_vdd_next;
            r_lvds  <= w_lvds_next;
            r_bl    <= w_bl_next;
            r_blank <= !w_ready_next;
            r_ready <= w_ready_next;
        end
    end

`ifdef LVDS_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] c_wd_last = (FRAME_TIMEOUT == '0) ? '0 : FRAME_TIMEOUT - c_one;

    // Cycles spent in RUN since entry or since the last frame_start.
    logic [CNT_W-1:0] r_wd;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
        end else if ((r_state == c_st_run) && (w_next == c_st_run) && !frame_start) begin
            r_wd <= r_wd + c_one;
        end else begin
            r_wd <= '0;
        end
    end

    assign w_timeout = (r_state == c_st_run) && !frame_start && (r_wd == c_wd_last);
    assign fault     = r_fault;
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign fault        = 1'b0;
    assign w_unused_cfg = ^{FRAME_TIMEOUT, r_fault};
`endif

    assign panel_vdd_en = r_vdd;
    assign lvds_en      = r_lvds;
    assign backlight_en = r_bl;
    assign blank        = r_blank;
    assign ready        = r_ready;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lvds_panel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvds_panel_sequencer
// Purpose  : Self-checking bench for lvds_panel_sequencer. A cycle model of
//            the sequencer pushes the expected output vector for each driven
//            cycle into a queue; the vector is popped and compared after the
//            clock edge. A second instance with a zero VDD dwell checks the
//            minimum-dwell case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lvds_panel_sequencer;

    localparam int c_t_vdd     = 4;
    localparam int c_t_lvds_bl = 3;
    localparam int c_t_bl_lvds = 2;
    localparam int c_t_lvds_vd = 2;
    localparam int c_t_off     = 5;
    localparam int c_ft        = 20;
`ifdef LVDS_SEQ_WATCHDOG_EN
    localparam bit c_wd_en = 1'b1;
`else
    localparam bit c_wd_en = 1'b0;
`endif
    // {state, vdd, lvds, backlight, blank, ready, fault}
    localparam logic [8:0] c_reset_vec = 9'b000_0_0_0_1_0_0;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       power_req;
    logic       frame_start;
    logic       panel_vdd_en, lvds_en, backlight_en, blank, ready, fault;
    logic [2:0] state;
    logic       t0_vdd, t0_lvds, t0_bl, t0_blank, t0_ready, t0_fault;
    logic [2:0] t0_state;

    always #5 clk_in = ~clk_in;

    lvds_panel_sequencer #(
        .CNT_W(24), .T_VDD_LVDS(24'd4), .T_LVDS_BL(24'd3), .T_BL_LVDS(24'd2),
        .T_LVDS_VDD(24'd2), .T_OFF_MIN(24'd5), .FRAME_TIMEOUT(24'd20)
    ) u_dut (
        .clk_in(clk_in), .rst_n(rst_n), .power_req(power_req), .frame_start(frame_start),
        .panel_vdd_en(panel_vdd_en), .lvds_en(lvds_en), .backlight_en(backlight_en),
        .blank(blank), .ready(ready), .state(state), .fault(fault)
    );

    lvds_panel_sequencer #(
        .CNT_W(24), .T_VDD_LVDS(24'd0), .T_LVDS_BL(24'd3), .T_BL_LVDS(24'd2),
        .T_LVDS_VDD(24'd2), .T_OFF_MIN(24'd5), .FRAME_TIMEOUT(24'd20)
    ) u_dut_t0 (
        .clk_in(clk_in), .rst_n(rst_n), .power_req(power_req), .frame_start(frame_start),
        .panel_vdd_en(t0_vdd), .lvds_en(t0_lvds), .backlight_en(t0_bl),
        .blank(t0_blank), .ready(t0_ready), .state(t0_state), .fault(t0_fault)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    int m_state, m_age, m_wd;
    bit m_framed, m_fault;

    function automatic int dwell_of(input int st);
        int t;
        case (st)
            1:       t = c_t_vdd;
            2:       t = c_t_lvds_bl;
            4:       t = c_t_bl_lvds;
            5:       t = c_t_lvds_vd;
            6:       t = c_t_off;
            default: t = 1;
        endcase
        return (t < 1) ? 1 : t;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_age    = 0;
        m_wd     = 0;
        m_framed = 1'b0;
        m_fault  = 1'b0;
    endtask

    task automatic model_step(input logic pr, input logic fs, output logic [8:0] e);
        int nxt;
        bit fr;
        bit expired;
        bit vdd, lvds, bl, rdy;
        nxt     = m_state;
        fr      = 1'b0;
        expired = (m_age + 1 >= dwell_of(m_state));
        case (m_state)
            0: if (!pr) m_fault = 1'b0; else if (!m_fault) nxt = 1;
            1: if (!pr) nxt = 6; else if (expired) nxt = 2;
            2: if (!pr) nxt = 5; else if (expired) nxt = 3;
            3: begin
                if (!pr) nxt = 4;
                else if (c_wd_en && !fs && (m_wd + 1 >= c_ft)) begin
                    nxt     = 4;
                    m_fault = 1'b1;
                end else fr = m_framed || fs;
            end
            4: if (expired) nxt = 5;
            5: if (expired) nxt = 6;
            6: if (expired) nxt = 0;
            default: nxt = 0;
        endcase
        m_wd     = (m_state == 3 && nxt == 3 && !fs) ? m_wd + 1 : 0;
        m_age    = (nxt == m_state) ? m_age + 1 : 0;
        m_state  = nxt;
        m_framed = fr;
        vdd  = (nxt >= 1 && nxt <= 5);
        lvds = (nxt >= 2 && nxt <= 4);
        bl   = (nxt == 3);
        rdy  = (nxt == 3) && fr;
        e = {nxt[2:0], vdd, lvds, bl, !rdy, rdy, m_fault};
    endtask

    // ------------------------------------------------------------- stimulus
    task automatic cycle(input logic pr, input logic fs);
        logic [8:0] e;
        logic [8:0] got;
        logic       inv;
        @(negedge clk_in);
        power_req   = pr;
        frame_start = fs;
        model_step(pr, fs, e);
        sb_q.push_back(e);
        @(posedge clk_in);
        #1;
        got = {state, panel_vdd_en, lvds_en, backlight_en, blank, ready, fault};
        e   = sb_q.pop_front();
        chk("outputs", {23'b0, got}, {23'b0, e});
        inv = !(backlight_en && !lvds_en) && !(lvds_en && !panel_vdd_en) &&
              !(t0_bl && !t0_lvds) && !(t0_lvds && !t0_vdd);
        chk("invariant", {31'b0, inv}, 32'd1);
    endtask

    task automatic run(input int n, input logic pr);
        for (int i = 0; i < n; i++) cycle(pr, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        power_req   = 1'b0;
        frame_start = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset", {23'b0, state, panel_vdd_en, lvds_en, backlight_en, blank, ready, fault},
            {23'b0, c_reset_vec});
        @(negedge clk_in);
        rst_n = 1'b1;
        run(2, 1'b0);

        // Power-up; frame_start in LVDS_ON is ignored, RUN frame at k+10.
        cycle(1'b1, 1'b0);
        chk("t0_vdd_lvds_k", {30'b0, t0_vdd, t0_lvds}, 32'b10);
        cycle(1'b1, 1'b0);
        chk("t0_lvds_k1", {31'b0, t0_lvds}, 32'd1);
        for (int i = 2; i <= 9; i++) cycle(1'b1, (i == 5));
        cycle(1'b1, 1'b1);
        run(3, 1'b1);

        // Power-down with power_req re-raised during COOL.
        run(5, 1'b0);
        run(6, 1'b1);

        // Abort two cycles after entering LVDS_ON.
        run(5, 1'b1);
        run(9, 1'b0);

        // Asynchronous reset mid-RUN.
        run(7, 1'b1);
        cycle(1'b1, 1'b1);
        run(2, 1'b1);
        @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {23'b0, state, panel_vdd_en, lvds_en, backlight_en, blank, ready, fault},
            {23'b0, c_reset_vec});
        model_reset();
        @(negedge clk_in);
        power_req = 1'b0;
        rst_n     = 1'b1;
        run(2, 1'b0);

        // frame_start coincident with power_req drop in RUN.
        run(9, 1'b1);
        cycle(1'b0, 1'b1);
        run(10, 1'b0);

        // Frame watchdog (or persistent RUN without it).
        run(42, 1'b1);
        cycle(1'b0, 1'b0);
        run(3, 1'b1);
        run(12, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
